// File: rtl/if_id_ex_pipe_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_id_ex_pipe_if : hazard-control, Decode-input and pipeline-output bundle
//                    for if_id_ex_pipe.  Revision 1.0
// ---------------------------------------------------------------------------
interface if_id_ex_pipe_if #(
  parameter int XLEN  = 32,
  parameter int CTRLW = 12
);
  logic [31:0]       InstrF;
  logic [XLEN-1:0]   PCTargetE;
  logic              PCSrcE;
  logic              StallF;
  logic              StallD;
  logic              FlushD;
  logic              FlushE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic [XLEN-1:0]   RD1D;
  logic [XLEN-1:0]   RD2D;
  logic [XLEN-1:0]   ImmExtD;
  logic [1:0]        ResultSrcD;
  logic [CTRLW-1:0]  CtrlD;
  logic [XLEN-1:0]   ALUResultM;
  logic [XLEN-1:0]   ResultW;

  logic [XLEN-1:0]   PCF;
  logic [31:0]       InstrD;
  logic [4:0]        Rs1D;
  logic [4:0]        Rs2D;
  logic [4:0]        RdD;
  logic [XLEN-1:0]   PCE;
  logic [XLEN-1:0]   PCPlus4E;
  logic [XLEN-1:0]   ImmExtE;
  logic [4:0]        Rs1E;
  logic [4:0]        Rs2E;
  logic [4:0]        RdE;
  logic [1:0]        ResultSrcE;
  logic              ResultSrcE_zero;
  logic [CTRLW-1:0]  CtrlE;
  logic [XLEN-1:0]   SrcAE;
  logic [XLEN-1:0]   WriteDataE;
  logic              ValidD;
  logic              ValidE;
  logic [15:0]       StallCnt;
  logic [15:0]       FlushCnt;

  modport master (
    output InstrF, PCTargetE, PCSrcE, StallF, StallD, FlushD, FlushE,
           ForwardAE, ForwardBE, RD1D, RD2D, ImmExtD, ResultSrcD, CtrlD,
           ALUResultM, ResultW,
    input  PCF, InstrD, Rs1D, Rs2D, RdD, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E,
           RdE, ResultSrcE, ResultSrcE_zero, CtrlE, SrcAE, WriteDataE,
           ValidD, ValidE, StallCnt, FlushCnt
  );

  modport slave (
    input  InstrF, PCTargetE, PCSrcE, StallF, StallD, FlushD, FlushE,
           ForwardAE, ForwardBE, RD1D, RD2D, ImmExtD, ResultSrcD, CtrlD,
           ALUResultM, ResultW,
    output PCF, InstrD, Rs1D, Rs2D, RdD, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E,
           RdE, ResultSrcE, ResultSrcE_zero, CtrlE, SrcAE, WriteDataE,
           ValidD, ValidE, StallCnt, FlushCnt
  );
endinterface
`default_nettype wire

// File: rtl/if_id_ex_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_id_ex_pipe : PC, IF/ID and ID/EX registers with stall/flush, operand
//                 forwarding and bring-up event counters.  Revision 1.0
// ---------------------------------------------------------------------------
module if_id_ex_pipe #(
  parameter int              XLEN     = 32,
  parameter int              CTRLW    = 12,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  wire logic       clk,
  input  wire logic       reset,
  if_id_ex_pipe_if.slave  bus
);
  localparam logic [31:0]     c_nop  = 32'h0000_0013;
  localparam logic [XLEN-1:0] c_four = XLEN'(4);
  localparam logic [15:0]     c_sat  = 16'hFFFF;

  logic [XLEN-1:0]  r_pcf;
  logic [XLEN-1:0]  w_pcplus4_f;

  logic [31:0]      r_instr_d;
  logic [XLEN-1:0]  r_pc_d;
  logic [XLEN-1:0]  r_pcplus4_d;
  logic             r_valid_d;

  logic [XLEN-1:0]  r_rd1_e;
  logic [XLEN-1:0]  r_rd2_e;
  logic [XLEN-1:0]  r_imm_e;
  logic [XLEN-1:0]  r_pc_e;
  logic [XLEN-1:0]  r_pcplus4_e;
  logic [4:0]       r_rs1_e;
  logic [4:0]       r_rs2_e;
  logic [4:0]       r_rd_e;
  logic [1:0]       r_resultsrc_e;
  logic [CTRLW-1:0] r_ctrl_e;
  logic             r_valid_e;

  logic [15:0]      r_stall_cnt;
  logic [15:0]      r_flush_cnt;

  logic [XLEN-1:0]  w_src_a;
  logic [XLEN-1:0]  w_src_b;

  assign w_pcplus4_f = r_pcf + c_four;

  // Redirect outranks stall so a taken branch is never dropped.
  always_ff @(posedge clk) begin
    if (reset)
      r_pcf <= RESET_PC;
    else if (bus.PCSrcE)
      r_pcf <= bus.PCTargetE;
    else if (!bus.StallF)
      r_pcf <= w_pcplus4_f;
  end

  always_ff @(posedge clk) begin
    if (reset || bus.FlushD) begin
      r_instr_d   <= c_nop;
      r_pc_d      <= '0;
      r_pcplus4_d <= '0;
      r_valid_d   <= 1'b0;
    end else if (!bus.StallD) begin
      r_instr_d   <= bus.InstrF;
      r_pc_d      <= r_pcf;
      r_pcplus4_d <= w_pcplus4_f;
      r_valid_d   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.FlushE) begin
      r_rd1_e       <= '0;
      r_rd2_e       <= '0;
      r_imm_e       <= '0;
      r_pc_e        <= '0;
      r_pcplus4_e   <= '0;
      r_rs1_e       <= '0;
      r_rs2_e       <= '0;
      r_rd_e        <= '0;
      r_resultsrc_e <= '0;
      r_ctrl_e      <= '0;
      r_valid_e     <= 1'b0;
    end else begin
      r_rd1_e       <= bus.RD1D;
      r_rd2_e       <= bus.RD2D;
      r_imm_e       <= bus.ImmExtD;
      r_pc_e        <= r_pc_d;
      r_pcplus4_e   <= r_pcplus4_d;
      r_rs1_e       <= r_instr_d[19:15];
      r_rs2_e       <= r_instr_d[24:20];
      r_rd_e        <= r_instr_d[11:7];
      r_resultsrc_e <= bus.ResultSrcD;
      r_ctrl_e      <= bus.CtrlD;
      r_valid_e     <= r_valid_d;
    end
  end

  // A cycle with both FlushD and FlushE counts as a single flush event.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (bus.StallD && (r_stall_cnt != c_sat))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if ((bus.FlushD || bus.FlushE) && (r_flush_cnt != c_sat))
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  // Select 2'b11 is reserved and falls back to the register-file value.
  always_comb begin
    w_src_a = r_rd1_e;
    case (bus.ForwardAE)
      2'b01:   w_src_a = bus.ResultW;
      2'b10:   w_src_a = bus.ALUResultM;
      default: w_src_a = r_rd1_e;
    endcase
  end

  always_comb begin
    w_src_b = r_rd2_e;
    case (bus.ForwardBE)
      2'b01:   w_src_b = bus.ResultW;
      2'b10:   w_src_b = bus.ALUResultM;
      default: w_src_b = r_rd2_e;
    endcase
  end

  assign bus.PCF             = r_pcf;
  assign bus.InstrD          = r_instr_d;
  assign bus.Rs1D            = r_instr_d[19:15];
  assign bus.Rs2D            = r_instr_d[24:20];
  assign bus.RdD             = r_instr_d[11:7];
  assign bus.ValidD          = r_valid_d;
  assign bus.PCE             = r_pc_e;
  assign bus.PCPlus4E        = r_pcplus4_e;
  assign bus.ImmExtE         = r_imm_e;
  assign bus.Rs1E            = r_rs1_e;
  assign bus.Rs2E            = r_rs2_e;
  assign bus.RdE             = r_rd_e;
  assign bus.ResultSrcE      = r_resultsrc_e;
  assign bus.ResultSrcE_zero = r_resultsrc_e[0];
  assign bus.CtrlE           = r_ctrl_e;
  assign bus.ValidE          = r_valid_e;
  assign bus.SrcAE           = w_src_a;
  assign bus.WriteDataE      = w_src_b;
  assign bus.StallCnt        = r_stall_cnt;
  assign bus.FlushCnt        = r_flush_cnt;
endmodule
`default_nettype wire

// File: tb/tb_if_id_ex_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_if_id_ex_pipe : directed bench for if_id_ex_pipe.  Revision 1.0
// ---------------------------------------------------------------------------
module tb_if_id_ex_pipe;
  logic clk = 1'b0;
  logic rst1;
  logic rst2;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] q_d[$];
  logic [4:0]  q_e[$];

  always #5 clk = ~clk;

  if_id_ex_pipe_if #(.XLEN(32), .CTRLW(12)) b ();
  if_id_ex_pipe_if #(.XLEN(32), .CTRLW(12)) b2 ();

  if_id_ex_pipe #(.XLEN(32), .CTRLW(12), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(rst1), .bus(b)
  );
  if_id_ex_pipe #(.XLEN(32), .CTRLW(12), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(rst2), .bus(b2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    b.PCSrcE = 1'b0; b.StallF = 1'b0; b.StallD = 1'b0;
    b.FlushD = 1'b0; b.FlushE = 1'b0;
  endtask

  initial begin
    logic [31:0] words [4];
    logic [31:0] exp_a [4];
    logic [31:0] exp_b [4];
    words = '{32'h0010_0093, 32'h0020_0113, 32'h0030_8193, 32'h0041_0213};
    exp_a = '{32'h11, 32'h33, 32'h22, 32'h11};
    exp_b = '{32'h44, 32'h33, 32'h22, 32'h44};

    rst1 = 1'b1; rst2 = 1'b1;
    b.InstrF = '0; b.PCTargetE = '0; clear_ctl();
    b.ForwardAE = 2'b00; b.ForwardBE = 2'b00; b.RD1D = '0; b.RD2D = '0;
    b.ImmExtD = '0; b.ResultSrcD = '0; b.CtrlD = '0; b.ALUResultM = '0; b.ResultW = '0;
    b2.InstrF = 32'h0010_0093; b2.PCTargetE = '0; b2.PCSrcE = 1'b0;
    b2.StallF = 1'b0; b2.StallD = 1'b0; b2.FlushD = 1'b0; b2.FlushE = 1'b0;
    b2.ForwardAE = 2'b00; b2.ForwardBE = 2'b00; b2.RD1D = 32'h77; b2.RD2D = 32'h66;
    b2.ImmExtD = '0; b2.ResultSrcD = 2'b01; b2.CtrlD = 12'h5A5;
    b2.ALUResultM = '0; b2.ResultW = '0;

    step(); step();
    chk("rst_pcf", b.PCF, 32'h0);
    chk("rst_instrd", b.InstrD, 32'h13);
    chk("rst_validd", 32'(b.ValidD), 32'h0);
    chk("rst_valide", 32'(b.ValidE), 32'h0);
    chk("rst_rdd", 32'(b.RdD), 32'h0);
    chk("rst_srcae", b.SrcAE, 32'h0);
    chk("rst_ctrle", 32'(b.CtrlE), 32'h0);
    chk("rst_stallcnt", 32'(b.StallCnt), 32'h0);
    chk("rst_flushcnt", 32'(b.FlushCnt), 32'h0);

    rst1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("idle_pcf", b.PCF, 32'(4 * i));
      b.InstrF = words[i];
      q_d.push_back(words[i]);
      q_e.push_back(words[i][11:7]);
      step();
      chk("idle_instrd", b.InstrD, q_d.pop_front());
      if (i >= 1) chk("idle_rde", 32'(b.RdE), 32'(q_e.pop_front()));
      chk("idle_valide", 32'(b.ValidE), 32'(i >= 1));
    end
    chk("idle_pcf_end", b.PCF, 32'h10);

    b.InstrF = 32'h0020_8133;
    q_d.push_back(32'h0020_8133);
    q_e.push_back(5'd2);
    step();
    chk("lu_instrd", b.InstrD, q_d.pop_front());
    chk("lu_rde_prev", 32'(b.RdE), 32'(q_e.pop_front()));

    b.StallF = 1'b1; b.StallD = 1'b1; b.FlushE = 1'b1;
    b.InstrF = 32'h0041_8233; b.CtrlD = 12'hABC; b.ResultSrcD = 2'b01; b.ImmExtD = 32'h55;
    step();
    chk("lu_pcf_hold", b.PCF, 32'h14);
    chk("lu_instrd_hold", b.InstrD, 32'h0020_8133);
    chk("lu_valide", 32'(b.ValidE), 32'h0);
    chk("lu_ctrle", 32'(b.CtrlE), 32'h0);
    chk("lu_rsz", 32'(b.ResultSrcE_zero), 32'h0);
    chk("lu_stallcnt", 32'(b.StallCnt), 32'h1);
    chk("lu_flushcnt", 32'(b.FlushCnt), 32'h1);

    clear_ctl();
    q_d.push_back(32'h0041_8233);
    step();
    chk("lu_rs1e", 32'(b.Rs1E), 32'h1);
    chk("lu_rs2e", 32'(b.Rs2E), 32'h2);
    chk("lu_rde", 32'(b.RdE), 32'(q_e.pop_front()));
    chk("lu_valide2", 32'(b.ValidE), 32'h1);
    chk("lu_ctrle2", 32'(b.CtrlE), 32'hABC);
    chk("lu_imme", b.ImmExtE, 32'h55);
    chk("lu_pce", b.PCE, 32'h10);
    chk("lu_pcplus4e", b.PCPlus4E, 32'h14);
    chk("lu_rsz2", 32'(b.ResultSrcE_zero), 32'h1);
    chk("lu_instrd_next", b.InstrD, q_d.pop_front());
    chk("lu_pcf_next", b.PCF, 32'h18);
    chk("dec_rs1d", 32'(b.Rs1D), 32'h3);
    chk("dec_rs2d", 32'(b.Rs2D), 32'h4);
    chk("dec_rdd", 32'(b.RdD), 32'h4);

    b.PCSrcE = 1'b1; b.PCTargetE = 32'h100; b.FlushD = 1'b1; b.FlushE = 1'b1;
    step();
    chk("br_pcf", b.PCF, 32'h100);
    chk("br_instrd", b.InstrD, 32'h13);
    chk("br_validd", 32'(b.ValidD), 32'h0);
    chk("br_valide", 32'(b.ValidE), 32'h0);
    chk("br_flushcnt", 32'(b.FlushCnt), 32'h2);

    clear_ctl();
    b.InstrF = 32'h0050_0293;
    step();
    chk("run_pcf", b.PCF, 32'h104);
    chk("run_instrd", b.InstrD, 32'h0050_0293);
    chk("run_validd", 32'(b.ValidD), 32'h1);

    b.PCSrcE = 1'b1; b.PCTargetE = 32'h100; b.StallF = 1'b1; b.StallD = 1'b1;
    b.FlushD = 1'b1; b.FlushE = 1'b1;
    step();
    chk("brst_pcf", b.PCF, 32'h100);
    chk("brst_instrd", b.InstrD, 32'h13);
    chk("brst_validd", 32'(b.ValidD), 32'h0);
    chk("brst_valide", 32'(b.ValidE), 32'h0);
    chk("brst_stallcnt", 32'(b.StallCnt), 32'h2);
    chk("brst_flushcnt", 32'(b.FlushCnt), 32'h3);

    clear_ctl();
    b.RD1D = 32'h11; b.RD2D = 32'h44;
    step();
    b.RD1D = 32'h99; b.RD2D = 32'h99; b.ALUResultM = 32'h22; b.ResultW = 32'h33;
    for (int s = 0; s < 4; s++) begin
      b.ForwardAE = 2'(s); b.ForwardBE = 2'(s);
      #1;
      chk("fwd_srcae", b.SrcAE, exp_a[s]);
      chk("fwd_wde", b.WriteDataE, exp_b[s]);
    end

    chk("bnd_rst_pcf", b2.PCF, 32'hFFFF_FFFC);
    rst2 = 1'b0;
    step();
    chk("bnd_wrap_pcf", b2.PCF, 32'h0);
    b2.StallF = 1'b1; b2.StallD = 1'b1;
    repeat (65534) step();
    chk("bnd_stall_fffe", 32'(b2.StallCnt), 32'hFFFE);
    step(); step();
    chk("bnd_stall_sat", 32'(b2.StallCnt), 32'hFFFF);
    chk("bnd_pcf_hold", b2.PCF, 32'h0);
    chk("bnd_pre_valide", 32'(b2.ValidE), 32'h1);

    b2.PCSrcE = 1'b1; b2.PCTargetE = 32'h40; b2.FlushD = 1'b1;
    rst2 = 1'b1;
    step();
    chk("mrst_pcf", b2.PCF, 32'hFFFF_FFFC);
    chk("mrst_stallcnt", 32'(b2.StallCnt), 32'h0);
    chk("mrst_flushcnt", 32'(b2.FlushCnt), 32'h0);
    chk("mrst_instrd", b2.InstrD, 32'h13);
    chk("mrst_validd", 32'(b2.ValidD), 32'h0);
    chk("mrst_valide", 32'(b2.ValidE), 32'h0);
    chk("mrst_rdd", 32'(b2.RdD), 32'h0);
    chk("mrst_ctrle", 32'(b2.CtrlE), 32'h0);
    chk("mrst_rsz", 32'(b2.ResultSrcE_zero), 32'h0);
    chk("mrst_srcae", b2.SrcAE, 32'h0);
    chk("mrst_wde", b2.WriteDataE, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/if_id_ex_pipe.md
# if_id_ex_pipe

Front-end pipeline-register block for the 5-stage RV32I core. It is the consumer side of the hazard unit's control outputs: it holds the PC and the IF/ID and ID/EX registers, and applies StallF/StallD/FlushD/FlushE. It also applies the forwarding selects ForwardAE/ForwardBE to Execute operands, and returns the register fields and load flag the hazard unit needs. Stall/flush event counters are included for bring-up.

## Interface
- XLEN, 32, datapath width
- CTRLW, 12, width of opaque Decode control word; all-zero must encode "no side effects"
- RESET_PC, 32'h0000_0000, PC value after reset
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- InstrF  in  32  instruction from instruction memory at PCF
- PCTargetE  in  XLEN  branch/jump target from Execute
- PCSrcE  in  1  redirect PC to PCTargetE
- StallF, StallD, FlushD, FlushE  in  1 each  hazard-unit controls
- ForwardAE, ForwardBE  in  2 each  operand forward selects
- RD1D, RD2D, ImmExtD  in  XLEN each  register-file reads and immediate, Decode stage
- ResultSrcD  in  2  result select; bit 0 = load
- CtrlD  in  CTRLW  remaining Decode control
- ALUResultM, ResultW  in  XLEN each  forwarding sources
- PCF  out  XLEN  fetch PC
- InstrD  out  32  Decode instruction
- Rs1D, Rs2D, RdD  out  5 each  InstrD[19:15], [24:20], [11:7]
- PCE, PCPlus4E, ImmExtE  out  XLEN each  Execute-stage values
- Rs1E, Rs2E, RdE  out  5 each  registered register fields
- ResultSrcE  out  2;  ResultSrcE_zero  out  1  = ResultSrcE[0]
- CtrlE  out  CTRLW  registered control
- SrcAE, WriteDataE  out  XLEN each  forwarded operands
- ValidD, ValidE  out  1 each  stage holds a real instruction
- StallCnt, FlushCnt  out  16 each  saturating event counters

## Operation
- PC register. Priority: reset → RESET_PC; else PCSrcE → PCTargetE; else StallF → hold; else PCF+4.
- A redirect is never lost: PCSrcE overrides StallF.
- PC+4 arithmetic is modulo 2^XLEN; it wraps from 0xFFFF_FFFC to 0.
- IF/ID register (InstrD, PCD, PCPlus4D, ValidD). Priority: reset or FlushD → bubble; else StallD → hold; else load InstrF, PCF, PCF+4, ValidD=1.
- Bubble values: InstrD = 32'h0000_0013 (addi x0,x0,0), PCD = PCPlus4D = 0, ValidD = 0.
- ID/EX register has no stall input. Priority: reset or FlushE → clear; else load from Decode.
- Clear values: every field is 0, including CtrlE, ResultSrcE, Rs1E/Rs2E/RdE and ValidE.
- On load, ValidE takes ValidD.
- Forwarding muxes are combinational:
  - 00 → RD1E/RD2E.
  - 01 → ResultW.
  - 10 → ALUResultM.
  - 11 is reserved and behaves as 00.
  - SrcAE uses ForwardAE; WriteDataE uses ForwardBE.
- StallCnt increments on any cycle with StallD=1 and reset=0; it saturates at 16'hFFFF.
- FlushCnt increments on any cycle with (FlushD|FlushE)=1 and reset=0; it counts once per cycle, not per signal, and saturates at 16'hFFFF.
- Both counters reset to 0.

## Timing
- All registers update on the rising edge of clk; reset is sampled only at clk.
- Reset values:
  - PCF = RESET_PC.
  - InstrD = NOP, ValidD = 0, PCD = PCPlus4D = 0.
  - All E-stage registers = 0, ValidE = 0.
  - StallCnt = FlushCnt = 0.
- Reset derived outputs: Rs1D = Rs2D = RdD = 0, ResultSrcE_zero = 0, SrcAE = WriteDataE = 0 if the forward selects are 00.
- Latency: an instruction fetched at edge n appears in InstrD after edge n+1 and in E-stage outputs after edge n+2, absent stalls and flushes.
- Rs1D/Rs2D/RdD, ResultSrcE_zero, SrcAE and WriteDataE are combinational from registers and inputs, with no added cycle. This lets the hazard unit close its loop in the same cycle.
- Load-use bubble (StallF=StallD=FlushE=1 for one cycle): PCF and IF/ID hold, and ID/EX clears. The next cycle, the same Decode instruction loads into E.
- Taken branch (PCSrcE=FlushD=FlushE=1): PCF ← PCTargetE, and both IF/ID and ID/EX become bubbles in the same edge.
- StallD and FlushD asserted together: flush wins.
- Reset mid-stall or mid-redirect: reset wins over everything, including PCSrcE.
- Reset deassertion: the first fetch issues at RESET_PC on the first edge with reset=0, and PCF becomes RESET_PC+4 after that edge.

## Test plan
- Reset, then 4 idle cycles with InstrF = distinct words and no hazards:
  - PCF = 0,4,8,C,10.
  - InstrD lags InstrF by 1 cycle; RdE lags RdD by 1 cycle.
  - ValidE rises 2 cycles after reset drops.
- Load-use: hold StallF=StallD=FlushE=1 for one cycle with InstrD = 32'h0020_8133:
  - PCF and InstrD hold; ValidE=0 and CtrlE=0 after the edge.
  - The next cycle, Rs1E=1, Rs2E=2, RdE=2.
  - StallCnt=1, FlushCnt=1.
- Redirect: PCSrcE=1, PCTargetE=32'h0000_0100, FlushD=FlushE=1:
  - PCF=0x100; InstrD=0x13; ValidD=ValidE=0.
  - Repeat with StallF=1 also asserted: PCF must still become 0x100.
- Forwarding, with RD1E=0x11, ALUResultM=0x22, ResultW=0x33:
  - ForwardAE=00/01/10/11 gives SrcAE=0x11/0x33/0x22/0x11.
  - Same check for WriteDataE via ForwardBE.
- Boundary: RESET_PC=32'hFFFF_FFFC, one free-run cycle → PCF=0.
  - Force 65,536 stall cycles → StallCnt stays at 16'hFFFF.
  - Assert reset mid-stall → all outputs return to their reset values on the next edge.
